// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures committed register-file writes from the CPU
// writeback trace port into a first-word-fall-through FIFO, drained over a
// valid/ready port. Counts commits and drops; sticky overflow flag.
module wb_trace_fifo #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int FILTER_R0 = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   debug_wb_pc,
  input  logic [3:0]    debug_wb_rf_wen,
  input  logic [4:0]    debug_wb_rf_wnum,
  input  logic [31:0]   debug_wb_rf_wdata,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [31:0]   trace_pc,
  output logic [3:0]    trace_wen,
  output logic [4:0]    trace_wnum,
  output logic [31:0]   trace_wdata,
  output logic [AW:0]   fifo_count,
  output logic [31:0]   commit_cnt,
  output logic [15:0]   drop_cnt,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [72:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_commit;
  logic [15:0]   r_drop;
  logic          r_ovf;

  logic          w_cap;
  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [72:0]   w_rec;
  logic [72:0]   w_head;

  assign w_cap   = (debug_wb_rf_wen != 4'b0000) &&
                   ((FILTER_R0 == 0) || (debug_wb_rf_wnum != 5'd0));
  assign w_full  = (r_count == FULL_CNT);
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & trace_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = w_cap & (~w_full | w_pop);
  assign w_drop  = w_cap & w_full & ~w_pop;
  assign w_rec   = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
  assign w_head  = r_mem[r_rptr];

  assign trace_valid = w_valid;
  assign {trace_pc, trace_wen, trace_wnum, trace_wdata} = w_head;
  assign fifo_count  = r_count;
  assign commit_cnt  = r_commit;
  assign drop_cnt    = r_drop;
  assign overflow    = r_ovf;

  // Record storage; never cleared, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wptr] <= w_rec;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Commit counter counts every capture, pushed or dropped, wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_commit <= '0;
    end else if (w_cap) begin
      r_commit <= r_commit + 32'd1;
    end
  end

  // Drop counter (saturating) and sticky overflow; a clear beats a same-cycle drop.
  always_ff @(posedge clk) begin
    if (reset || ovf_clr) begin
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

endmodule
